// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants used by
// both the transmitter and the existing receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DEFAULT_CLK_DIV = 104;
  localparam int DATA_BITS       = 8;
  localparam int STOP_BITS       = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with an extra pointer bit so full and empty can be told
// apart when the wrapped read and write addresses are equal.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_level = r_wrPtr - r_rdPtr;
  assign o_data  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage is not reset; flushing the pointers is enough to discard it.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a small FIFO feeds a bit FSM, the registered line
// drops for the start bit on the same edge the head byte is popped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          hw_clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uarttx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = 1;
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e r_state, w_nextState;
  logic [7:0]    r_shift, w_nextShift;
  logic [2:0]    r_bitCnt, w_nextBitCnt;
  logic [CW-1:0] r_baud, w_nextBaud;
  logic          r_uarttx, w_nextTx;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_baudDone;
  logic [7:0]    w_fifoData;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (hw_clk),
    .i_rst   (rst),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign tx_ready   = !w_full;
  assign uarttx     = r_uarttx;
  assign busy       = (r_state != IDLE) || (fifo_level != '0);
  assign w_baudDone = (r_baud == BAUD_LAST);

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_baud   <= '0;
      r_uarttx <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_shift  <= w_nextShift;
      r_bitCnt <= w_nextBitCnt;
      r_baud   <= w_nextBaud;
      r_uarttx <= w_nextTx;
    end
  end

  // Every bit boundary reloads the baud counter to zero, so bit times never drift.
  always_comb begin
    w_nextState  = r_state;
    w_nextShift  = r_shift;
    w_nextBitCnt = r_bitCnt;
    w_nextBaud   = r_baud + BAUD_ONE;
    w_nextTx     = r_uarttx;
    w_pop        = 1'b0;
    if (w_baudDone) w_nextBaud = '0;
    case (r_state)
      IDLE: begin
        w_nextTx     = 1'b1;
        w_nextBaud   = '0;
        w_nextBitCnt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextShift = w_fifoData;
          w_nextState = START;
          w_nextTx    = 1'b0;
        end
      end
      START: begin
        if (w_baudDone) begin
          w_nextState  = DATA;
          w_nextBitCnt = '0;
          w_nextTx     = r_shift[0];
        end
      end
      DATA: begin
        if (w_baudDone) begin
          if (r_bitCnt == BIT_LAST) begin
            w_nextState = STOP;
            w_nextTx    = 1'b1;
          end else begin
            w_nextShift  = {1'b0, r_shift[7:1]};
            w_nextBitCnt = r_bitCnt + 3'd1;
            w_nextTx     = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_baudDone) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nextShift = w_fifoData;
            w_nextState = START;
            w_nextTx    = 1'b0;
          end else begin
            w_nextState = IDLE;
            w_nextTx    = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextTx    = 1'b1;
      end
    endcase
  end

endmodule
